// File: rtl/float_pkg.sv
// float_pkg: shared float format helpers and divider FSM states.
// FLOAT_DIV_ROUND_EN adds the guard-bit iteration used for round-to-nearest-even.
package float_pkg;

    typedef enum logic [1:0] {IDLE, DIVIDE, NORMALIZE, DONE} divState_t;

    function automatic int expBias(input int exponentSize);
        return (1 << (exponentSize - 1)) - 1;
    endfunction

    function automatic int expInf(input int exponentSize);
        return (1 << exponentSize) - 1;
    endfunction

    function automatic int mantCalcSize(input int mantissaSize);
`ifdef FLOAT_DIV_ROUND_EN
        return mantissaSize + 3;
`else
        return mantissaSize + 2;
`endif
    endfunction

endpackage

// File: rtl/float_unpack.sv
// float_unpack: splits a packed float into sign, exponent and hidden-bit mantissa.
// Exponent zero reads as signed zero (denormals flushed); all-ones reads as infinity.
module float_unpack
    import float_pkg::*;
#(
    parameter int MANTISSA_SIZE = 23,
    parameter int EXPONENT_SIZE = 8
) (
    input  logic [EXPONENT_SIZE+MANTISSA_SIZE:0] value,
    output logic                                 sign,
    output logic [EXPONENT_SIZE-1:0]             exponent,
    output logic [MANTISSA_SIZE:0]               mantissa,
    output logic                                 isZero,
    output logic                                 isInf
);

    assign sign     = value[EXPONENT_SIZE+MANTISSA_SIZE];
    assign exponent = value[EXPONENT_SIZE+MANTISSA_SIZE-1 -: EXPONENT_SIZE];
    assign isZero   = exponent == '0;
    assign isInf    = &exponent;
    assign mantissa = {!isZero, value[MANTISSA_SIZE-1:0]};

endmodule

// File: rtl/float_div.sv
// float_div: iterative restoring float divider, one quotient bit per clock, valid/ready on both sides.
// Define FLOAT_DIV_ROUND_EN for round-to-nearest-even; the default build truncates.
module float_div
    import float_pkg::*;
#(
    parameter int MANTISSA_SIZE = 23,
    parameter int EXPONENT_SIZE = 8
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [EXPONENT_SIZE+MANTISSA_SIZE:0] dividendIn,
    input  logic [EXPONENT_SIZE+MANTISSA_SIZE:0] divisorIn,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [EXPONENT_SIZE+MANTISSA_SIZE:0] quot
);

    localparam int FLOAT_SIZE         = 1 + EXPONENT_SIZE + MANTISSA_SIZE;
    localparam int EXPONENT_BIAS      = expBias(EXPONENT_SIZE);
    localparam int EXPONENT_INF       = expInf(EXPONENT_SIZE);
    localparam int MANTISSA_CALC_SIZE = mantCalcSize(MANTISSA_SIZE);
    localparam int N  = MANTISSA_CALC_SIZE;
    localparam int EW = EXPONENT_SIZE + 2;
    localparam int CW = $clog2(N);

    logic                     aSign, bSign, aZero, bZero, aInf, bInf;
    logic [EXPONENT_SIZE-1:0] aExp, bExp;
    logic [MANTISSA_SIZE:0]   aMant, bMant;

    float_unpack #(.MANTISSA_SIZE(MANTISSA_SIZE), .EXPONENT_SIZE(EXPONENT_SIZE)) unpackA (
        .value(dividendIn), .sign(aSign), .exponent(aExp), .mantissa(aMant), .isZero(aZero), .isInf(aInf)
    );
    float_unpack #(.MANTISSA_SIZE(MANTISSA_SIZE), .EXPONENT_SIZE(EXPONENT_SIZE)) unpackB (
        .value(divisorIn), .sign(bSign), .exponent(bExp), .mantissa(bMant), .isZero(bZero), .isInf(bInf)
    );

    divState_t                state, nextState;
    logic [MANTISSA_SIZE+1:0] rem, remSub;
    logic [MANTISSA_SIZE:0]   divisor;
    logic [N-1:0]             q;
    logic [CW-1:0]            cnt;
    logic [EW-1:0]            expBase, expFinal;
    logic [MANTISSA_SIZE-1:0] mant;
    logic                     resSign, accept, special, bitOut, adj, flush, ovf;

    assign s_ready = state == IDLE;
    assign accept  = s_valid && s_ready;
    assign special = aZero || aInf || bZero || bInf;
    assign bitOut  = rem >= {1'b0, divisor};
    assign remSub  = bitOut ? rem - {1'b0, divisor} : rem;
    // Quotient lies in (0.5, 2); a clear integer bit means one extra left shift.
    assign adj     = !q[N-1];

`ifdef FLOAT_DIV_ROUND_EN
    logic [MANTISSA_SIZE-1:0] mantTrunc;
    logic                     guard, sticky, carry;
    assign mantTrunc       = q[N-1] ? q[N-2 -: MANTISSA_SIZE] : q[N-3 -: MANTISSA_SIZE];
    assign guard           = q[N-1] ? q[1] : q[0];
    assign sticky          = (q[N-1] && q[0]) || (rem != '0);
    assign {carry, mant}   = {1'b0, mantTrunc} + (MANTISSA_SIZE+1)'(guard && (sticky || mantTrunc[0]));
    assign expFinal        = expBase - EW'(adj) + EW'(carry);
`else
    assign mant     = q[N-1] ? q[N-2 -: MANTISSA_SIZE] : q[N-3 -: MANTISSA_SIZE];
    assign expFinal = expBase - EW'(adj);
`endif

    assign flush = $signed(expFinal) <= 0;
    assign ovf   = $signed(expFinal) >= EXPONENT_INF;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:      if (accept) nextState = special ? DONE : DIVIDE;
            DIVIDE:    if (cnt == '0) nextState = NORMALIZE;
            NORMALIZE: nextState = DONE;
            DONE:      if (m_valid && m_ready) nextState = IDLE;
            default:   nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem     <= '0;
            divisor <= '0;
            q       <= '0;
            cnt     <= '0;
            expBase <= '0;
            resSign <= 1'b0;
            quot    <= '0;
            m_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    resSign <= aSign ^ bSign;
                    rem     <= {1'b0, aMant};
                    divisor <= bMant;
                    q       <= '0;
                    cnt     <= CW'(N - 1);
                    expBase <= EW'(aExp) - EW'(bExp) + EW'(EXPONENT_BIAS);
                    // Specials land in quot now; m_valid follows one edge later from DONE.
                    if (special) quot <= {aSign ^ bSign, {EXPONENT_SIZE{bZero || aInf}}, {MANTISSA_SIZE{1'b0}}};
                end
                DIVIDE: begin
                    rem <= remSub << 1;
                    q   <= {q[N-2:0], bitOut};
                    cnt <= cnt - 1'b1;
                end
                NORMALIZE: begin
                    quot    <= flush ? {resSign, {(FLOAT_SIZE-1){1'b0}}}
                             : ovf   ? {resSign, {EXPONENT_SIZE{1'b1}}, {MANTISSA_SIZE{1'b0}}}
                             :         {resSign, expFinal[EXPONENT_SIZE-1:0], mant};
                    m_valid <= 1'b1;
                end
                DONE:    m_valid <= !(m_valid && m_ready);
                default: ;
            endcase
        end
    end

endmodule
